// File: rtl/btn_evt_pkg.sv
// Shared types for the push-button event controller: event codes,
// repeat-FSM states and the packed event word pushed into the FIFO.
package btn_evt_pkg;

    localparam int NUM_BTN = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        PRESS   = 2'b00,
        REPEAT  = 2'b01,
        RELEASE = 2'b10
    } evt_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DAS  = 2'b01,
        ARR  = 2'b10
    } rpt_state_e;

    // FIFO word as seen by the MicroBlaze: {type[1:0], idx[1:0]}
    typedef struct packed {
        evt_type_e        evt_type;
        logic [IDX_W-1:0] idx;
    } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer followed by a consecutive-mismatch
// debounce counter. rise_o/fall_o are combinational and assert in the
// same cycle level_o is about to toggle, so the caller can act on the
// very edge that updates the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle;

    // Counter clears on agreement, else counts until the level flips
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        toggle  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
            toggle  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = toggle & ~level_q;
    assign fall_o  = toggle &  level_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Push-button event controller: debounced buttons feed per-button
// press/auto-repeat/release FSMs, each with a one-entry pending slot.
// A round-robin arbiter moves slots into a show-ahead event FIFO.
// Handshake: the head (evt_data) is valid whenever evt_valid=1; an entry
// is popped on a clock edge where evt_valid && evt_ready; evt_ready while
// empty has no effect.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned          DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned          DAS_CYCLES      = 16_000_000,
    parameter int unsigned          ARR_CYCLES      = 5_000_000,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = 4'b1111,
    parameter int unsigned          FIFO_DEPTH      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_BTN-1:0]              btn_raw,
    output logic [3:0]                      evt_data,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]     evt_count,
    output logic [NUM_BTN-1:0]              btn_level,
    output logic                            overflow,
    input  logic                            ovf_clr,
    output logic [2*NUM_BTN-1:0]            dbg_rpt_state_o
);

    localparam int unsigned TMR_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [TMR_W-1:0] DAS_LAST = TMR_W'(DAS_CYCLES - 1);
    localparam logic [TMR_W-1:0] ARR_LAST = TMR_W'(ARR_CYCLES - 1);

    // ---------------- debounce ----------------
    logic [NUM_BTN-1:0] rise, fall;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .btn_raw_i (btn_raw[g]),
            .level_o   (btn_level[g]),
            .rise_o    (rise[g]),
            .fall_o    (fall[g])
        );
    end

    // ---------------- repeat FSMs ----------------
    rpt_state_e         state_q [NUM_BTN];
    rpt_state_e         state_d [NUM_BTN];
    logic [TMR_W-1:0]   tmr_q   [NUM_BTN];
    logic [TMR_W-1:0]   tmr_d   [NUM_BTN];
    logic [NUM_BTN-1:0] emit;
    evt_type_e          emit_type [NUM_BTN];

    // Next state, timer and event emission; release beats a same-cycle repeat
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]   = state_q[i];
            tmr_d[i]     = tmr_q[i];
            emit[i]      = 1'b0;
            emit_type[i] = PRESS;
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        emit[i]    = 1'b1;
                        state_d[i] = DAS;
                        tmr_d[i]   = '0;
                    end
                end
                DAS: begin
                    if (fall[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = RELEASE;
                        state_d[i]   = IDLE;
                        tmr_d[i]     = '0;
                    end else if (tmr_q[i] == DAS_LAST) begin
                        // Non-repeating buttons park here with the timer held
                        if (REPEAT_MASK[i]) begin
                            emit[i]      = 1'b1;
                            emit_type[i] = REPEAT;
                            state_d[i]   = ARR;
                            tmr_d[i]     = '0;
                        end
                    end else begin
                        tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    end
                end
                ARR: begin
                    if (fall[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = RELEASE;
                        state_d[i]   = IDLE;
                        tmr_d[i]     = '0;
                    end else if (tmr_q[i] == ARR_LAST) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = REPEAT;
                        tmr_d[i]     = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    tmr_d[i]   = '0;
                end
            endcase
        end
    end

    // FSM state and timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= IDLE;
                tmr_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
        end
    end

    // Expose FSM states, two bits per button
    always_comb begin
        dbg_rpt_state_o = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            dbg_rpt_state_o[2*i +: 2] = state_q[i];
        end
    end

    // ---------------- slots and arbiter ----------------
    logic [NUM_BTN-1:0] slot_vld_q, slot_vld_d;
    evt_type_e          slot_typ_q [NUM_BTN];
    evt_type_e          slot_typ_d [NUM_BTN];
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gnt_idx, cand;
    logic               gnt_vld;
    logic               drop;
    logic               push, pop, full, can_write;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    assign can_write = ~full | pop;

    // Round-robin search starting one past the last grant
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        if (can_write) begin
            for (int k = 1; k <= NUM_BTN; k++) begin
                cand = last_q + IDX_W'(k);
                if (!gnt_vld && slot_vld_q[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        last_d = gnt_vld ? gnt_idx : last_q;
        push   = gnt_vld;
    end

    // Slot update: granted slot empties, emitted events fill empty slots or are dropped
    always_comb begin
        slot_vld_d = slot_vld_q;
        drop       = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            slot_typ_d[i] = slot_typ_q[i];
        end
        if (gnt_vld) begin
            slot_vld_d[gnt_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (emit[i]) begin
                if (!slot_vld_q[i]) begin
                    slot_vld_d[i] = 1'b1;
                    slot_typ_d[i] = emit_type[i];
                end else begin
                    drop = 1'b1;
                end
            end
        end
        // A same-cycle drop wins over the clear
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Slot, arbiter and overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                slot_typ_q[i] <= PRESS;
            end
            last_q <= IDX_W'(NUM_BTN - 1);
            ovf_q  <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                slot_typ_q[i] <= slot_typ_d[i];
            end
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- show-ahead FIFO ----------------
    btn_evt_t         mem_q [FIFO_DEPTH];
    btn_evt_t         wr_evt;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    // Occupancy follows push/pop; a full FIFO with a pop may still push
    always_comb begin
        wr_evt.evt_type = slot_typ_q[gnt_idx];
        wr_evt.idx      = gnt_idx;
        count_d         = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_evt;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign evt_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with short debounce/repeat timings.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_btn_event_ctrl;
    import btn_evt_pkg::*;

    localparam int DEB   = 4;
    localparam int DASC  = 20;
    localparam int ARRC  = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] evt_data;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [2:0] evt_count;
    logic [3:0] btn_level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic [7:0] dbg_rpt_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    btn_event_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DAS_CYCLES      (DASC),
        .ARR_CYCLES      (ARRC),
        .REPEAT_MASK     (4'b1111),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_raw         (btn_raw),
        .evt_data        (evt_data),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_count       (evt_count),
        .btn_level       (btn_level),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr),
        .dbg_rpt_state_o (dbg_rpt_state)
    );

    // ---------------- driver tasks ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        btn_raw   = 4'b0000;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        step(3);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"},    evt_valid, 1'b0);
        check_eq({tag, "_count"},    evt_count, 3'd0);
        check_eq({tag, "_data"},     evt_data, 4'h0);
        check_eq({tag, "_level"},    btn_level, 4'h0);
        check_eq({tag, "_overflow"}, overflow, 1'b0);
        check_eq({tag, "_state"},    dbg_rpt_state, 8'h00);
    endtask

    // Guard against a hung run
    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus and scoreboard ----------------
    initial begin
        logic       exp_v;
        logic [3:0] exp_d;
        logic [3:0] seq [6];

        // Reset state
        do_reset();
        check_reset_values("reset");

        // Glitch on btn 2 for 3 cycles: nothing happens
        btn_raw[2] = 1'b1;
        step(3);
        btn_raw[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check_eq($sformatf("glitch_valid_c%0d", c), evt_valid, 1'b0);
            check_eq($sformatf("glitch_level_c%0d", c), btn_level, 4'h0);
        end

        // Hold btn 1 for 40 cycles: PRESS, REPEATs, RELEASE at exact cycles
        do_reset();
        btn_raw[1] = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            step(1);
            if (c == 40) btn_raw[1] = 1'b0;
            exp_v = (c == 7 || c == 27 || c == 35 || c == 43 || c == 47);
            exp_d = (c == 7) ? 4'b0001 : (c == 47) ? 4'b1001 : 4'b0101;
            check_eq($sformatf("hold_valid_c%0d", c), evt_valid, exp_v);
            if (exp_v) check_eq($sformatf("hold_data_c%0d", c), evt_data, exp_d);
            if (c == 5)  check_eq("hold_level_before", btn_level, 4'b0000);
            if (c == 6)  check_eq("hold_level_rise", btn_level, 4'b0010);
            if (c == 30) check_eq("hold_state_arr", dbg_rpt_state[3:2], 2'b10);
            if (c == 45) check_eq("hold_level_held", btn_level, 4'b0010);
            if (c == 46) check_eq("hold_level_fall", btn_level, 4'b0000);
        end

        // All four buttons in the same cycle: PRESS idx 0,1,2,3 back to back
        do_reset();
        btn_raw = 4'b1111;
        for (int c = 1; c <= 11; c++) begin
            step(1);
            exp_v = (c >= 7 && c <= 10);
            check_eq($sformatf("multi_valid_c%0d", c), evt_valid, exp_v);
            if (exp_v) begin
                exp_d = 4'(c - 7);
                check_eq($sformatf("multi_data_c%0d", c), evt_data, exp_d);
            end
        end

        // Stalled consumer: six events, four stored, one pending, one dropped
        do_reset();
        evt_ready = 1'b0;
        seq[0] = 4'b0010; seq[1] = 4'b0000; seq[2] = 4'b0100;
        seq[3] = 4'b0000; seq[4] = 4'b1000; seq[5] = 4'b0000;
        for (int s = 0; s < 6; s++) begin
            btn_raw = seq[s];
            step(8);
            if (s == 4) check_eq("stall_no_ovf_yet", overflow, 1'b0);
        end
        check_eq("stall_count", evt_count, 3'd4);
        check_eq("stall_overflow", overflow, 1'b1);
        check_eq("stall_valid", evt_valid, 1'b1);
        check_eq("stall_level", btn_level, 4'h0);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0011);
        check_eq("stall_head", evt_data, exp_q.pop_front());

        // Drain with ovf_clr: full FIFO pops and pushes in the same cycle
        evt_ready = 1'b1;
        ovf_clr   = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("drain_overflow_clr", overflow, 1'b0);
        check_eq("drain_count_full", evt_count, 3'd4);
        for (int c = 0; c < 8; c++) begin
            if (evt_valid) begin
                if (exp_q.size() == 0) check_eq("drain_extra", evt_valid, 1'b0);
                else check_eq($sformatf("drain_data_%0d", c), evt_data, exp_q.pop_front());
            end
            step(1);
        end
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("drain_empty", evt_valid, 1'b0);
        check_eq("drain_count_zero", evt_count, 3'd0);

        // Reset while btn 3 repeats with events queued, then fresh PRESS
        do_reset();
        evt_ready = 1'b0;
        btn_raw[3] = 1'b1;
        step(30);
        check_eq("rst_pre_state_arr", dbg_rpt_state[7:6], 2'b10);
        check_eq("rst_pre_count", evt_count, 3'd2);
        check_eq("rst_pre_level", btn_level, 4'b1000);
        reset = 1'b1;
        step(1);
        check_reset_values("rst_mid");
        reset = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step(1);
            check_eq($sformatf("rst_post_valid_c%0d", c), evt_valid, (c == 7));
        end
        check_eq("rst_post_data", evt_data, 4'b0011);
        check_eq("rst_post_count", evt_count, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Debounces the four board push-buttons, generates Tetris-style key events (press, delayed-auto-repeat, release), and arbitrates them round-robin into a small event FIFO read by the MicroBlaze through a GPIO input channel with a valid/ready pop. It sits between the raw `btn` pins and the MicroBlaze GPIO/interrupt logic in the top level. This replaces software polling of raw button levels.

## Interface

- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `DAS_CYCLES`, 16_000_000: hold time from PRESS to first REPEAT.
- `ARR_CYCLES`, 5_000_000: period between subsequent REPEATs.
- `REPEAT_MASK`, 4'b1111: per-button repeat enable; bit clear means PRESS/RELEASE only.
- `FIFO_DEPTH`, 8: event FIFO entries, power of two, ≥2.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  raw buttons, active-high = pressed (top level inverts board polarity); asynchronous.
- `evt_data`  out  4  head event {type[1:0], idx[1:0]}.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer pops head when high with `evt_valid`.
- `evt_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `btn_level`  out  4  debounced button levels.
- `overflow`  out  1  sticky: an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation

- Per button: 2-FF synchronizer, then debounce counter. Counter clears whenever synchronized value equals `btn_level[i]`; otherwise it increments; at DEBOUNCE_CYCLES consecutive mismatches `btn_level[i]` toggles and the counter clears.
- Per-button repeat FSM, states IDLE, DAS, ARR:
  - IDLE: rising `btn_level` → emit PRESS, go to DAS, clear timer.
  - DAS: timer reaches DAS_CYCLES → emit REPEAT, go to ARR, clear timer. If REPEAT_MASK[i]=0, stay in DAS without emitting.
  - ARR: every ARR_CYCLES → emit REPEAT.
  - DAS/ARR: falling `btn_level` → emit RELEASE, go to IDLE; release takes priority over a same-cycle repeat.
- Event type codes: PRESS=2'b00, REPEAT=2'b01, RELEASE=2'b10; 2'b11 never produced.
- Each button has a one-entry pending slot. An emitted event loads the slot if empty. If the slot is full, the new event is dropped and `overflow` is set.
- Round-robin arbiter grants one non-empty slot per cycle when the FIFO can accept a write. Search starts at last grant + 1.
- The FIFO can accept a write when not full, or when full with a same-cycle pop. The granted slot is written to the FIFO and cleared.
- FIFO is show-ahead: `evt_data` is the head whenever `evt_valid`=1. A pop occurs on `evt_valid && evt_ready`. `evt_ready` while empty is ignored.
- `overflow`: if a set and `ovf_clr` occur in the same cycle, set wins.

## Timing

- Reset: `btn_level`=0, sync FFs=0, all counters and timers 0, FSMs IDLE, slots empty, FIFO empty (`evt_valid`=0, `evt_count`=0, `evt_data`=0), `overflow`=0, arbiter last-grant=3 so button 0 has first priority.
- Button held through reset deassertion: after reset it is treated as a fresh press, and PRESS is emitted after the normal debounce time.
- Raw edge at cycle 0, held: `btn_level` toggles after edge 2+DEBOUNCE_CYCLES. The slot loads on that same edge. The FIFO write happens on the next edge, so `evt_valid` rises at 3+DEBOUNCE_CYCLES when the FIFO is empty and uncontended.
- Any raw glitch shorter than DEBOUNCE_CYCLES produces no event and no `btn_level` change.
- First REPEAT slot-load is exactly DAS_CYCLES cycles after the PRESS slot-load. Each later REPEAT is exactly ARR_CYCLES after the previous one, independent of FIFO stalls.
- Pop-to-next-head: the next entry appears the cycle after the pop. Push into an empty FIFO is visible one cycle after the write edge.

## Structure

- `btn_evt_pkg`:
  - `evt_type_e` (PRESS/REPEAT/RELEASE)
  - `rpt_state_e` (IDLE/DAS/ARR)
  - packed struct `btn_evt_t` {type, idx}
  - `NUM_BTN`=4
- Sub-module `btn_debounce`: synchronizer plus debounce counter, one instance per button.
- Repeat FSMs, slots, arbiter and FIFO live in `btn_event_ctrl`.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, DAS_CYCLES=20, ARR_CYCLES=8, FIFO_DEPTH=4, `evt_ready`=1 unless stated.

- Raw pulse on btn 2 held for 3 cycles → no `btn_level` change, no event.
- Press btn 1 and hold 40 cycles → PRESS 4'b0001 at cycle 7, then REPEAT 4'b0101 at +20, then +28, then +36. On release → RELEASE 4'b1001.
- Buttons 0–3 pressed in the same cycle → PRESS events in order idx 0,1,2,3 on consecutive cycles.
- `evt_ready`=0, 6 distinct press/release events generated → `evt_count`=4, `overflow`=1, `evt_data` still the oldest event. Then pulse `ovf_clr` with `evt_ready`=1 → FIFO drains in order and `overflow` returns to 0.
- FIFO full with a same-cycle pop and push → `evt_count` stays 4 and the ordering is preserved.
- Assert `reset` while btn 3 is in ARR with the FIFO non-empty → all reset values hold the next cycle. With btn 3 still held, PRESS 4'b0011 appears 7 cycles after reset release.
